instr_fetch_unit: RTL and testbench

- Upstream stage of the single-cycle RV32I core. Owns the PC and fetches instructions from instruction memory over a req/ack handshake.
- Presents the held instruction and its decoded fields (opcode, funct3, funct7, rd, rs1, rs2) to the control unit and register file.
- Computes the next PC from the control unit's pc_select / is_branch / is_jump outputs plus the branch comparison result.

---
 rtl/instr_fetch_unit.sv | 204 ++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, fetches over imem req/ack, presents the instruction and its decoded fields.
// Latency: one cycle from ack to instr_valid; with FETCH_PREFETCH_EN defined, one instruction per cycle on sequential code.
// Backpressure: stall holds the presented instruction; imem_req/imem_addr stay stable until imem_ack.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic [1:0]  pc_select,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        fetch_fault
);

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [1:0] {FETCH, HOLD, HALT, KILL} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, instr_q, next_pc, pc_inc, addr_c;
  logic        fault_q, taken, req_c, load_instr, load_pc, set_fault;

`ifdef FETCH_PREFETCH_EN
  logic        pbuf_valid_q, pf_req_q;
  logic [31:0] pbuf_data_q, kill_addr_q;
  logic        instr_from_buf, pf_set, pf_clr, buf_fill, buf_clr, kill_ld;
`endif

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    taken   = is_jump | (is_branch & branch_taken);
    next_pc = pc_inc;
    if (pc_select == 2'b01 && taken)
      next_pc = pc_q + imm;
    else if (pc_select == 2'b10 && is_jump)
      next_pc = (rs1_data + imm) & ~32'h1;
  end

  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    addr_c     = pc_q;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    set_fault  = 1'b0;
`ifdef FETCH_PREFETCH_EN
    instr_from_buf = 1'b0;
    pf_set         = 1'b0;
    pf_clr         = 1'b0;
    buf_fill       = 1'b0;
    buf_clr        = 1'b0;
    kill_ld        = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = HOLD;
`ifdef FETCH_PREFETCH_EN
          pf_set = 1'b1;
`endif
        end
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        req_c  = pf_req_q;
        addr_c = pc_inc;
        if (pf_req_q && imem_ack) begin
          buf_fill = 1'b1;
          pf_clr   = 1'b1;
        end
`endif
        if (!stall) begin
          if (next_pc[1:0] != 2'b00) begin
            set_fault = 1'b1;
            state_d   = HALT;
`ifdef FETCH_PREFETCH_EN
            buf_clr = 1'b1;
            pf_clr  = 1'b1;
`endif
          end else begin
            load_pc = 1'b1;
`ifdef FETCH_PREFETCH_EN
            buf_clr = 1'b1;
            if (next_pc == pc_inc) begin
              if (pbuf_valid_q) begin
                load_instr     = 1'b1;
                instr_from_buf = 1'b1;
                pf_set         = 1'b1;
              end else if (pf_req_q && imem_ack) begin
                load_instr = 1'b1;
                pf_set     = 1'b1;
              end else begin
                // in-flight prefetch already targets the new pc: it becomes the demand fetch
                state_d = FETCH;
                pf_clr  = 1'b1;
              end
            end else begin
              pf_clr = 1'b1;
              if (pf_req_q && !imem_ack) begin
                state_d = KILL;
                kill_ld = 1'b1;
              end else begin
                state_d = FETCH;
              end
            end
`else
            state_d = FETCH;
`endif
          end
        end
      end
`ifdef FETCH_PREFETCH_EN
      KILL: begin
        req_c  = 1'b1;
        addr_c = kill_addr_q;
        if (imem_ack)
          state_d = FETCH;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      if (load_pc)   pc_q    <= next_pc;
      if (set_fault) fault_q <= 1'b1;
`ifdef FETCH_PREFETCH_EN
      if (load_instr) instr_q <= instr_from_buf ? pbuf_data_q : imem_rdata;
`else
      if (load_instr) instr_q <= imem_rdata;
`endif
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbuf_valid_q <= 1'b0;
      pbuf_data_q  <= NOP_INSTR;
      pf_req_q     <= 1'b0;
      kill_addr_q  <= RESET_PC;
    end else begin
      if (pf_set)      pf_req_q <= 1'b1;
      else if (pf_clr) pf_req_q <= 1'b0;
      if (buf_clr) begin
        pbuf_valid_q <= 1'b0;
      end else if (buf_fill) begin
        pbuf_valid_q <= 1'b1;
        pbuf_data_q  <= imem_rdata;
      end
      if (kill_ld) kill_addr_q <= pc_inc;
    end
  end
`endif

  assign imem_req    = req_c & ~rst;
  assign imem_addr   = addr_c;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_valid ? instr_q : NOP_INSTR;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_inc;
  assign fetch_fault = fault_q;
  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign funct3      = instr[14:12];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign funct7      = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the memory responder acks after a programmable latency.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, stall, is_branch, is_jump, branch_taken;
  logic [31:0] imem_addr, imem_rdata, imm, rs1_data;
  logic [1:0]  pc_select;
  logic        instr_valid, fetch_fault;
  logic [31:0] instr, pc_out, pc_plus4;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   lat      = 0;
  int   cnt      = 0;
  logic ack_force = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
  endfunction

  assign imem_ack   = ack_force | (imem_req && (cnt >= lat));
  assign imem_rdata = ack_force ? 32'hDEAD_BEEF : memf(imem_addr);

  always @(posedge clk) begin
    if (imem_ack || !imem_req) cnt <= 0;
    else                       cnt <= cnt + 1;
  end

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .is_branch(is_branch), .is_jump(is_jump), .pc_select(pc_select),
    .branch_taken(branch_taken), .imm(imm), .rs1_data(rs1_data),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .fetch_fault(fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ctl(input logic br, input logic jp, input logic [1:0] ps, input logic tk,
                     input logic [31:0] im, input logic [31:0] r1);
    is_branch    = br;
    is_jump      = jp;
    pc_select    = ps;
    branch_taken = tk;
    imm          = im;
    rs1_data     = r1;
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    repeat (2) step();
    chk("rst_req",   imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_instr", instr, NOP);
    rst = 1'b0;
    #1;
    chk("c1_req",  imem_req, 1);
    chk("c1_addr", imem_addr, 32'h0);
    step();
    chk("c2_valid",  instr_valid, 1);
    chk("c2_instr",  instr, 32'h0050_0093);
    chk("c2_opcode", opcode, 7'b0010011);
    chk("c2_rd",     rd, 5'd1);
`ifdef FETCH_PREFETCH_EN
    chk("pf_req",   imem_req, 1);
    chk("pf_addr",  imem_addr, 32'h4);
    step();
    chk("seq4_valid", instr_valid, 1);
    chk("seq4_pc",    pc_out, 32'h4);
    chk("seq4_instr", instr, memf(32'h4));
    step();
    chk("seq8_valid", instr_valid, 1);
    chk("seq8_pc",    pc_out, 32'h8);
    step();
    chk("seqc_valid", instr_valid, 1);
    chk("seqc_instr", instr, memf(32'hC));
    lat = 2;
    ctl(0, 1, 2'b01, 0, 32'h34, 32'h0);
    step();
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    chk("kill_valid", instr_valid, 0);
    chk("kill_req",   imem_req, 1);
    chk("kill_addr",  imem_addr, 32'h10);
    step();
    chk("kill2_valid", instr_valid, 0);
    lat = 0;
    step();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_req",  imem_req, 1);
    step();
    chk("redir_instr", instr, memf(32'h40));
    chk("redir_pc",    pc_out, 32'h40);
`else
    chk("c2_rs2",   rs2, 5'd5);
    chk("c2_pc4",   pc_plus4, 32'h4);
    chk("c2_req",   imem_req, 0);
    step();
    chk("f4_req",    imem_req, 1);
    chk("f4_addr",   imem_addr, 32'h4);
    chk("f4_valid",  instr_valid, 0);
    chk("nop_instr", instr, NOP);
    chk("nop_rd",    rd, 5'd0);

    // late ack with stall held through the fetch and two held cycles
    lat   = 3;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("late_addr",  imem_addr, 32'h4);
      chk("late_req",   imem_req, 1);
      chk("late_valid", instr_valid, 0);
      step();
    end
    step();
    chk("late_instr", instr, memf(32'h4));
    chk("late_valid", instr_valid, 1);
    ack_force = 1'b1;
    step();
    chk("stall_instr", instr, memf(32'h4));
    chk("stall_pc",    pc_out, 32'h4);
    chk("stall_req",   imem_req, 0);
    ack_force = 1'b0;
    stall     = 1'b0;
    lat       = 0;
    step();
    chk("one_retire_pc",   pc_out, 32'h8);
    chk("one_retire_addr", imem_addr, 32'h8);

    step();
    ctl(0, 1, 2'b01, 0, 32'h8, 32'h0);
    step();
    chk("jal_addr", imem_addr, 32'h10);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(1, 0, 2'b01, 1, 32'hFFFF_FFF0, 32'h0);
    step();
    chk("beq_taken", imem_addr, 32'h0);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(0, 1, 2'b01, 0, 32'h10, 32'h0);
    step();
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(1, 0, 2'b01, 0, 32'hFFFF_FFF0, 32'h0);
    step();
    chk("beq_not_taken", imem_addr, 32'h14);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(0, 1, 2'b11, 0, 32'h100, 32'h0);
    step();
    chk("psel11_addr", imem_addr, 32'h18);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(0, 1, 2'b01, 0, 32'h8, 32'h0);
    step();
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    chk("jalr_pc4", pc_plus4, 32'h24);
    ctl(0, 1, 2'b10, 0, 32'h1, 32'h103);
    step();
    chk("jalr_addr", imem_addr, 32'h104);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    step();
    ctl(0, 1, 2'b10, 0, 32'h0, 32'h102);
    step();
    chk("fault_set",   fetch_fault, 1);
    chk("fault_req",   imem_req, 0);
    chk("fault_valid", instr_valid, 0);
    chk("fault_pc",    pc_out, 32'h104);
    ctl(0, 0, 2'b00, 0, 32'h0, 32'h0);
    ack_force = 1'b1;
    repeat (3) step();
    chk("halt_req",   imem_req, 0);
    chk("halt_fault", fetch_fault, 1);
    chk("halt_valid", instr_valid, 0);
    ack_force = 1'b0;

    // reset out of HALT, then reset again on top of an acked request
    rst = 1'b1;
    #1;
    chk("rst2_fault", fetch_fault, 0);
    chk("rst2_pc",    pc_out, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_req",  imem_req, 1);
    chk("rel_addr", imem_addr, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_req",   imem_req, 0);
    chk("mid_valid", instr_valid, 0);
    chk("mid_pc",    pc_out, 32'h0);
    step();
    chk("mid_instr", instr, NOP);
    rst = 1'b0;
    #1;
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req",  imem_req, 1);
    step();
    chk("restart_valid", instr_valid, 1);
    chk("restart_instr", instr, 32'h0050_0093);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
